// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
//
// Shares one external combinational 16-bit add/sub unit among NREQ requesters.
// A round-robin search picks one pending requester. Its operands go into
// registers that drive the adder. The adder outputs are captured one cycle
// later. The result is then offered on the response port, tagged with the
// requester index.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The source holds valid and its payload stable until that edge.
//   req_ready never depends on the payload, only on req_valid and state.
//   rsp_valid never depends on rsp_ready.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (ready is one-hot or 0)
//   req_A, req_B           packed operands, requester k at [W*k +: W]
//   req_ctrl               per-requester add(0)/sub(1) select
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 requester index of the result
//   rsp_sum/cout/ovf       captured adder outputs
//   add_A/add_B/add_ctrl   registered drive to the external adder
//   add_sum/cout/ovf       external adder outputs
//   busy                   high whenever the FSM is not IDLE
//   op_cnt                 completed-transaction counter (wraps)
//   dbg_state              current FSM state for observation
// -----------------------------------------------------------------------------
module adder_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [W*NREQ-1:0] req_A,
   input  logic [W*NREQ-1:0] req_B,
   input  logic [NREQ-1:0]   req_ctrl,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_cout,
   output logic              rsp_ovf,
   output logic [W-1:0]      add_A,
   output logic [W-1:0]      add_B,
   output logic              add_ctrl,
   input  logic [W-1:0]      add_sum,
   input  logic              add_cout,
   input  logic              add_ovf,
   output logic              busy,
   output logic [15:0]       op_cnt,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;

   // (base + off) mod NREQ. Both inputs are below NREQ, so one subtraction
   // is enough.
   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // Round-robin search starting at rr_ptr. The first set bit wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_found && req_valid[wrap_idx(rr_ptr, i)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_idx(rr_ptr, i);
         end
      end
   end

   // Next state and req_ready. Ready is suppressed while reset is asserted,
   // so no requester sees a handshake that the register stage will discard.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (rst_n && gnt_found) begin
               state_nxt          = EXEC;
               req_ready[gnt_idx] = 1'b1;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         add_A    <= '0;
         add_B    <= '0;
         add_ctrl <= 1'b0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_ovf  <= 1'b0;
         op_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  add_A    <= req_A[int'(gnt_idx)*W +: W];
                  add_B    <= req_B[int'(gnt_idx)*W +: W];
                  add_ctrl <= req_ctrl[gnt_idx];
                  rsp_id   <= gnt_idx;
                  // The winner moves to the lowest priority position.
                  rr_ptr   <= wrap_idx(gnt_idx, 1);
               end
            end
            EXEC: begin
               // add_* have been stable for a full cycle, so the adder has settled.
               rsp_sum  <= add_sum;
               rsp_cout <= add_cout;
               rsp_ovf  <= add_ovf;
            end
            RESP: begin
               if (rsp_ready) op_cnt <= op_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W*NREQ-1:0] req_A = '0;
  logic [W*NREQ-1:0] req_B = '0;
  logic [NREQ-1:0]   req_ctrl = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout, rsp_ovf;
  logic [W-1:0]      add_A, add_B, add_sum;
  logic              add_ctrl, add_cout, add_ovf;
  logic              busy;
  logic [15:0]       op_cnt;
  logic [1:0]        dbg_state;

  adder_share_arb #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_A(add_A), .add_B(add_B), .add_ctrl(add_ctrl),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .busy(busy), .op_cnt(op_cnt), .dbg_state(dbg_state)
  );

  // ---------------- behavioural adder ----------------
  logic [16:0] wide;
  always_comb begin
    wide     = {1'b0, add_A} + {1'b0, (add_ctrl ? ~add_B : add_B)} + {16'd0, add_ctrl};
    add_sum  = wide[15:0];
    add_cout = wide[16];
    if (add_ctrl)
      add_ovf = (add_A[15] != add_B[15]) && (add_sum[15] != add_A[15]);
    else
      add_ovf = (add_A[15] == add_B[15]) && (add_sum[15] != add_A[15]);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           gnt_q[$];
  int           id_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_A[k*W +: W] = a;
    req_B[k*W +: W] = b;
    req_ctrl[k]     = c;
  endtask

  // One complete transaction for requester id with rsp_ready high.
  task automatic do_txn(input int id, input logic [15:0] es);
    int n;
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("txn_grant_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    check("txn_rsp_timeout", 32'(n < 20), 32'd1);
    check("txn_rsp_id", 32'(rsp_id), id);
    check("txn_rsp_sum", 32'(rsp_sum), 32'(es));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] exp_sum[4];
  logic [1:0]  exp_co[4];   // {cout, ovf}
  int gnts, rsps, last, cyc, eid, seen;

  initial begin
    // Test 1: reset held with all requests pending
    rst_n = 1'b0;
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_op_cnt", 32'(op_cnt), 32'h0);
    check("rst_add_A", 32'(add_A), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Test 2: single request from requester 2, signed overflow
    set_op(2, 16'h7FFF, 16'h0001, 1'b0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    check("single_req_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    check("single_ready_drop", 32'(req_ready), 32'h0);
    check("single_add_A", 32'(add_A), 32'h7FFF);
    check("single_busy", 32'(busy), 32'h1);
    check("single_early_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_sum", 32'(rsp_sum), 32'h8000);
    check("single_ovf", 32'(rsp_ovf), 32'h1);
    check("single_cout", 32'(rsp_cout), 32'h0);
    check("single_cnt_pre", 32'(op_cnt), 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("single_cnt_post", 32'(op_cnt), 32'h1);
    check("single_valid_off", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b0;

    // Test 3: round-robin with all requesters pending
    reset_dut();
    set_op(0, 16'h1234, 16'h0011, 1'b0);
    set_op(1, 16'h0005, 16'h0007, 1'b1);
    set_op(2, 16'h8000, 16'h0001, 1'b1);
    set_op(3, 16'hFFFF, 16'hFFFF, 1'b0);
    exp_sum[0] = 16'h1245; exp_co[0] = 2'b00;
    exp_sum[1] = 16'hFFFE; exp_co[1] = 2'b00;
    exp_sum[2] = 16'h7FFF; exp_co[2] = 2'b11;
    exp_sum[3] = 16'hFFFE; exp_co[3] = 2'b10;
    gnt_q = '{0, 1, 2, 3, 0};
    id_q  = '{0, 1, 2, 3, 0};
    exp_q = '{16'h1245, 16'hFFFE, 16'h7FFF, 16'hFFFE, 16'h1245};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    gnts = 0; rsps = 0; last = 0; cyc = 0;
    while (rsps < 5 && cyc < 60) begin
      #1;
      if (req_ready != '0) begin
        if (gnt_q.size() > 0) begin
          eid = gnt_q.pop_front();
          check("rr_grant", 32'(req_ready), 32'd1 << eid);
        end else begin
          check("rr_extra_grant", 32'(req_ready), 32'h0);
        end
        if (gnts > 0) check("rr_spacing", cyc - last, 3);
        last = cyc;
        gnts++;
      end
      if (rsp_valid) begin
        if (id_q.size() > 0) begin
          eid = id_q.pop_front();
          check("rr_rsp_id", 32'(rsp_id), eid);
          check("rr_rsp_sum", 32'(rsp_sum), 32'(exp_q.pop_front()));
          check("rr_rsp_flags", 32'({rsp_cout, rsp_ovf}), 32'(exp_co[eid]));
        end else begin
          check("rr_extra_rsp", 32'(rsp_valid), 32'h0);
        end
        rsps++;
      end
      @(negedge clk);
      cyc++;
      if (gnts >= 5) req_valid = '0;
    end
    check("rr_rsp_count", rsps, 5);
    check("rr_op_cnt", 32'(op_cnt), 32'h5);
    rsp_ready = 1'b0;

    // Test 4: backpressure on requester 1 (rr_ptr now 1), requester 3 waiting
    set_op(1, 16'hFFFF, 16'h0001, 1'b0);
    req_valid = 4'b0010;
    #1;
    check("bp_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", 32'(rsp_valid), 32'h1);
      check("bp_sum_hold", 32'({rsp_cout, rsp_sum}), 32'h10000);
      check("bp_ready_low", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    check("bp_id", 32'(rsp_id), 32'h1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 32'(rsp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("bp_next_id", 32'(rsp_id), 32'h3);
    check("bp_next_sum", 32'(rsp_sum), 32'hFFFE);
    @(negedge clk);
    check("bp_op_cnt", 32'(op_cnt), 32'h7);
    rsp_ready = 1'b0;

    // Test 5: reset during EXEC (rr_ptr now 0, requester 2 alone wins)
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("mid_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    check("mid_in_exec", 32'(dbg_state), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_idle", 32'(busy), 32'h0);
    check("mid_rst_cnt", 32'(op_cnt), 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("mid_no_rsp", seen, 0);
    req_valid = 4'hF;
    #1;
    check("mid_ptr_reset", 32'(req_ready), 32'h1);
    do_txn(0, 16'h1245);

    // Test 6: op_cnt wrap
    rsp_ready = 1'b0;
    req_valid = '0;
    force dut.op_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.op_cnt;
    @(negedge clk);
    check("wrap_preload", 32'(op_cnt), 32'hFFFF);
    do_txn(1, 16'h0000);
    check("wrap_cnt", 32'(op_cnt), 32'h0);
    rsp_ready = 1'b0;

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
